// File: rtl/ins_fetch_ctrl_if.sv
// ins_fetch_ctrl_if: ROM, decoder and execute-stage signals
// of the instruction fetch controller.
interface ins_fetch_ctrl_if;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ins_word;
    logic        ins_load;
    logic [15:0] ext_word;
    logic        ext_valid;
    logic [1:0]  ext_index;
    logic        exec_start;
    logic        exec_done;
    logic        branch_taken;
    logic [15:0] branch_target;

    modport master (
        output rom_addr,
        input  rom_data,
        output ins_word,
        output ins_load,
        output ext_word,
        output ext_valid,
        output ext_index,
        output exec_start,
        input  exec_done,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  ins_word,
        input  ins_load,
        input  ext_word,
        input  ext_valid,
        input  ext_index,
        input  exec_start,
        output exec_done,
        output branch_taken,
        output branch_target
    );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: PC owner, ROM fetch and execute handshake.
// Optional macro FETCH_CTRL_ILLEGAL_TRAP_EN traps length code 3.
module ins_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    ins_fetch_ctrl_if.master      bus,
    output logic                  busy,
    output logic                  illegal
);
    typedef enum logic [3:0] {
        IDLE, FETCH, CAPTURE, DECODE,
        EXT_ADDR, EXT_CAP, ISSUE, EXEC_WAIT, TRAP
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] ins_word_q;
    logic [15:0] ext_word_q;
    logic [1:0]  ext_index_q;
    logic [1:0]  words_left_q;
    logic [1:0]  len_d;
    logic        ins_load_q;
    logic        ext_valid_q;
    logic        exec_start_q;
    logic        busy_q;
    logic        illegal_q;

    assign pc_d = pc_q + 16'd1;

`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
    assign len_d = ins_word_q[13:12];
`else
    assign len_d = (ins_word_q[13:12] == 2'd3) ? 2'd0 : ins_word_q[13:12];
`endif

    // Sequencer: state, PC, captured words and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ins_word_q   <= '0;
            ext_word_q   <= '0;
            ext_index_q  <= '0;
            words_left_q <= '0;
            ins_load_q   <= 1'b0;
            ext_valid_q  <= 1'b0;
            exec_start_q <= 1'b0;
            busy_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            ins_load_q   <= 1'b0;
            ext_valid_q  <= 1'b0;
            exec_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!run) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    ins_word_q <= bus.rom_data;
                    pc_q       <= pc_d;
                    ins_load_q <= 1'b1;
                    state_q    <= DECODE;
                end
                DECODE: begin
                    ext_index_q  <= '0;
                    words_left_q <= len_d;
`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
                    if (len_d == 2'd3) begin
                        illegal_q <= 1'b1;
                        state_q   <= TRAP;
                    end else
`endif
                    if (len_d == 2'd0) begin
                        exec_start_q <= 1'b1;
                        state_q      <= ISSUE;
                    end else begin
                        state_q <= EXT_ADDR;
                    end
                end
                EXT_ADDR: begin
                    state_q <= EXT_CAP;
                end
                EXT_CAP: begin
                    ext_word_q   <= bus.rom_data;
                    ext_valid_q  <= 1'b1;
                    ext_index_q  <= ext_index_q + 2'd1;
                    pc_q         <= pc_d;
                    words_left_q <= words_left_q - 2'd1;
                    if (words_left_q > 2'd1) begin
                        state_q <= EXT_ADDR;
                    end else begin
                        exec_start_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= EXEC_WAIT;
                end
                EXEC_WAIT: begin
                    if (bus.exec_done) begin
                        if (bus.branch_taken) begin
                            pc_q <= bus.branch_target;
                        end
                        state_q <= FETCH;
                    end
                end
`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
                TRAP: begin
                    state_q <= TRAP;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr   = pc_q;
    assign bus.ins_word   = ins_word_q;
    assign bus.ins_load   = ins_load_q;
    assign bus.ext_word   = ext_word_q;
    assign bus.ext_valid  = ext_valid_q;
    assign bus.ext_index  = ext_index_q;
    assign bus.exec_start = exec_start_q;
    assign busy           = busy_q;
    assign illegal        = illegal_q;
endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// tb_ins_fetch_ctrl: directed stimulus with a pulse scoreboard
// for ins_fetch_ctrl.
module tb_ins_fetch_ctrl;
    localparam int K_LOAD  = 0;
    localparam int K_EXT   = 1;
    localparam int K_START = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          aux;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        busy;
    logic        illegal;
    logic [15:0] rom [0:65535];
    logic [15:0] pc_m;
    int          cyc = 0;
    int          load_cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sbq [$];

    ins_fetch_ctrl_if bus ();

    ins_fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus.master),
        .busy    (busy),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input int kind, input logic [15:0] val,
                           input int aux);
        exp_t e;
        chk("sb_pending", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_kind", kind, e.kind);
            if (kind != K_START) chk("sb_word", val, e.val);
            if (kind != K_LOAD) chk("sb_aux", aux, e.aux);
        end
    endtask

    // Every pulse the DUT emits is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.ins_load) begin
            load_cyc = cyc;
            pop_cmp(K_LOAD, bus.ins_word, 0);
        end
        if (bus.ext_valid) pop_cmp(K_EXT, bus.ext_word, int'(bus.ext_index));
        if (bus.exec_start) pop_cmp(K_START, 16'h0, cyc - load_cyc);
    end

    // Called in a FETCH cycle; returns in the following FETCH cycle.
    task automatic do_instr(input bit early, input int wait_n,
                            input bit noise, input bit br,
                            input logic [15:0] tgt, input bit stop);
        int          fc;
        int          n;
        logic [15:0] w;
        logic [15:0] a;
        chk("fetch_addr", bus.rom_addr, pc_m);
        fc = cyc;
        w  = rom[pc_m];
        n  = (w[13:12] == 2'd3) ? 0 : int'(w[13:12]);
        sbq.push_back('{K_LOAD, w, 0});
        for (int i = 1; i <= n; i++) begin
            a = pc_m + 16'(i);
            sbq.push_back('{K_EXT, rom[a], i});
        end
        sbq.push_back('{K_START, 16'h0, 1 + 2 * n});
        for (int k = 0; k < 40 && !bus.exec_start; k++) tick();
        chk("start_seen", bus.exec_start, 1);
        chk("start_cycle", cyc - fc, 3 + 2 * n);
        pc_m = pc_m + 16'(1 + n);
        if (early) begin
            bus.exec_done     = 1'b1;
            bus.branch_taken  = 1'b1;
            bus.branch_target = 16'h1234;
        end
        tick();
        bus.exec_done    = 1'b0;
        bus.branch_taken = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
            bus.branch_taken  = noise;
            bus.branch_target = 16'h2222;
            tick();
        end
        bus.exec_done     = 1'b1;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        if (stop) run = 1'b0;
        tick();
        bus.exec_done    = 1'b0;
        bus.branch_taken = 1'b0;
        if (br) pc_m = tgt;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int fc;
        rst               = 1'b1;
        run               = 1'b0;
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0;
        for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
        rom[16'h0000] = 16'h0123;
        rom[16'h0001] = 16'h1A00;
        rom[16'h0002] = 16'h5555;
        rom[16'h0003] = 16'h0042;
        rom[16'h0004] = 16'h2A45;
        rom[16'h0005] = 16'hBEEF;
        rom[16'h0006] = 16'hCAFE;
        rom[16'h0040] = 16'h0840;
        rom[16'h0041] = 16'h0041;
        rom[16'h0080] = 16'h2000;
        rom[16'h0081] = 16'h1111;
        rom[16'h0082] = 16'h2222;
        rom[16'h0090] = 16'h3000;
        rom[16'hFFFF] = 16'h1F00;
        repeat (3) tick();

        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ins_load", bus.ins_load, 0);
        chk("rst_ext_valid", bus.ext_valid, 0);
        chk("rst_exec_start", bus.exec_start, 0);
        chk("rst_ins_word", bus.ins_word, 0);
        chk("rst_ext_word", bus.ext_word, 0);
        chk("rst_ext_index", bus.ext_index, 0);
        chk("rst_pc", bus.rom_addr, 16'h0000);

        rst = 1'b0;
        run = 1'b1;
        tick();
        chk("busy_fetch", busy, 1);
        pc_m = 16'h0000;

        do_instr(0, 0, 0, 0, 16'h0, 0);
        do_instr(0, 0, 0, 0, 16'h0, 0);
        do_instr(0, 0, 0, 0, 16'h0, 0);
        do_instr(1, 0, 0, 1, 16'h0040, 0);
        do_instr(0, 3, 1, 0, 16'h0, 0);
        do_instr(0, 1, 0, 1, 16'hFFFF, 0);
        do_instr(0, 0, 0, 0, 16'h0, 0);
        do_instr(0, 0, 0, 0, 16'h0, 1);

        chk("idle_pc_hold", bus.rom_addr, pc_m);
        tick();
        chk("idle_busy", busy, 0);
        tick();
        chk("idle_busy2", busy, 0);
        chk("idle_pc", bus.rom_addr, pc_m);
        run = 1'b1;
        tick();
        do_instr(0, 0, 0, 1, 16'h0080, 0);

        chk("fetch_addr_rst", bus.rom_addr, pc_m);
        sbq.push_back('{K_LOAD, rom[pc_m], 0});
        fc = cyc;
        while (cyc - fc < 4) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_ext_valid", bus.ext_valid, 0);
        chk("abort_exec_start", bus.exec_start, 0);
        chk("abort_pc", bus.rom_addr, 16'h0000);
        run = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_start", bus.exec_start, 0);
        end
        run  = 1'b1;
        pc_m = 16'h0000;
        tick();
        do_instr(0, 0, 0, 1, 16'h0090, 0);

`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
        chk("fetch_addr_trap", bus.rom_addr, pc_m);
        sbq.push_back('{K_LOAD, rom[pc_m], 0});
        repeat (3) tick();
        for (int k = 0; k < 20; k++) begin
            chk("trap_no_start", bus.exec_start, 0);
            chk("trap_busy", busy, 1);
            tick();
        end
        chk("trap_illegal", illegal, 1);
        chk("trap_pc", bus.rom_addr, pc_m + 16'd1);
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("trap_clear", illegal, 0);
`else
        do_instr(0, 0, 0, 0, 16'h0, 1);
        chk("no_illegal", illegal, 0);
`endif

        repeat (3) tick();
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
